refresh_sequencer: RTL and testbench



---
 rtl/refresh_sequencer.sv | 159 +++++++++++++++
 tb/tb_refresh_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_sequencer.sv
// Refresh sequencer: waits for the user port to go idle, then read/write-backs
// ROWS_PER_REQ rows from a wrapping row pointer. Optional stats via REFRESH_STATS_EN.
//
// state | meaning
// IDLE  | waiting for refresh_req
// GRANT | port claimed, letting an in-flight user op finish
// RD    | read strobe on current row
// WAIT  | latency down-counter running, capture at terminal count
// WR    | write-back of captured word, advance row pointer
// DONE  | cycle_done pulse, burst count cleared
module refresh_sequencer #(
  parameter int ROWS         = 64,
  parameter int ROWS_PER_REQ = 8,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 2,
  localparam int AW          = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_req,
  input  logic              user_active,
  output logic              cycle_done,
  output logic              refresh_busy,
  output logic              arr_rd_en,
  output logic              arr_wr_en,
  output logic [AW-1:0]     arr_addr,
  output logic [DATA_W-1:0] arr_wr_data,
  input  logic [DATA_W-1:0] arr_rd_data
`ifdef REFRESH_STATS_EN
  ,
  output logic [15:0]       stat_bursts,
  output logic [15:0]       stat_defer_cycles,
  output logic [AW-1:0]     stat_row_ptr
`endif
);

  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int BW = $clog2(ROWS_PER_REQ + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_RD, S_WAIT, S_WR, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       row_ptr_q, row_ptr_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [DATA_W-1:0]   cap_q, cap_d;

`ifdef REFRESH_STATS_EN
  logic [15:0] stat_bursts_q, stat_bursts_d;
  logic [15:0] stat_defer_q, stat_defer_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_ptr_q <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      lat_q     <= '0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      lat_q     <= lat_d;
      cap_q     <= cap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_ptr_d    = row_ptr_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    lat_d        = lat_q;
    cap_d        = cap_q;
    cycle_done   = 1'b0;
    refresh_busy = 1'b0;
    arr_rd_en    = 1'b0;
    arr_wr_en    = 1'b0;
    arr_addr     = addr_q;
    arr_wr_data  = cap_q;

    case (state_q)
      S_IDLE: begin
        if (refresh_req) state_d = S_GRANT;
      end
      S_GRANT: begin
        refresh_busy = 1'b1;
        if (!user_active) state_d = S_RD;
      end
      S_RD: begin
        refresh_busy = 1'b1;
        arr_rd_en    = 1'b1;
        arr_addr     = row_ptr_q;
        addr_d       = row_ptr_q;
        lat_d        = LW'(RD_LAT - 1);
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        refresh_busy = 1'b1;
        // terminal count lands exactly RD_LAT cycles after the read strobe
        if (lat_q == '0) begin
          cap_d   = arr_rd_data;
          state_d = S_WR;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_WR: begin
        refresh_busy = 1'b1;
        arr_wr_en    = 1'b1;
        arr_addr     = row_ptr_q;
        addr_d       = row_ptr_q;
        row_ptr_d    = row_ptr_q + AW'(1);
        burst_d      = burst_q + BW'(1);
        if (burst_q == BW'(ROWS_PER_REQ - 1)) state_d = S_DONE;
        else                                  state_d = S_RD;
      end
      S_DONE: begin
        refresh_busy = 1'b1;
        cycle_done   = 1'b1;
        burst_d      = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef REFRESH_STATS_EN
  always_comb begin
    stat_bursts_d = stat_bursts_q;
    stat_defer_d  = stat_defer_q;
    if (state_q == S_DONE && stat_bursts_q != 16'hFFFF)
      stat_bursts_d = stat_bursts_q + 16'd1;
    if (state_q == S_GRANT && user_active && stat_defer_q != 16'hFFFF)
      stat_defer_d = stat_defer_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_bursts_q <= '0;
      stat_defer_q  <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_defer_q  <= stat_defer_d;
    end
  end

  assign stat_bursts       = stat_bursts_q;
  assign stat_defer_cycles = stat_defer_q;
  assign stat_row_ptr      = row_ptr_q;
`endif

endmodule

// File: tb/tb_refresh_sequencer.sv
// Bench for refresh_sequencer: delayed-read array model, write-back scoreboard,
// table of refresh requests plus hand-written reset and spacing sequences.
module tb_refresh_sequencer;

  localparam int ROWS   = 64;
  localparam int RPR    = 8;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst;
  logic          refresh_req;
  logic          user_active;
  logic          cycle_done;
  logic          refresh_busy;
  logic          arr_rd_en;
  logic          arr_wr_en;
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_wr_data;
  logic [DW-1:0] arr_rd_data;

  refresh_sequencer #(
    .ROWS(ROWS), .ROWS_PER_REQ(RPR), .DATA_W(DW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .refresh_req(refresh_req), .user_active(user_active),
    .cycle_done(cycle_done), .refresh_busy(refresh_busy),
    .arr_rd_en(arr_rd_en), .arr_wr_en(arr_wr_en), .arr_addr(arr_addr),
    .arr_wr_data(arr_wr_data), .arr_rd_data(arr_rd_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // array model: read data appears RD_LAT cycles after the strobe, junk otherwise
  logic [DW-1:0] mem [0:ROWS-1];
  logic          hv  [0:RD_LAT-1];
  logic [AW-1:0] ha  [0:RD_LAT-1];
  logic [DW-1:0] junk_q = 32'h5A5A_0001;

  always @(posedge clk) begin
    hv[0] <= arr_rd_en;
    ha[0] <= arr_addr;
    for (int k = 1; k < RD_LAT; k++) begin
      hv[k] <= hv[k-1];
      ha[k] <= ha[k-1];
    end
    junk_q <= junk_q + 32'h9E37_79B9;
  end

  assign arr_rd_data = hv[RD_LAT-1] ? mem[ha[RD_LAT-1]] : junk_q;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  sb_t sb[$];
  int  exp_ptr   = 0;
  int  rd_cnt    = 0;
  int  done_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      sb_t e;
      check("strobe_excl", {63'd0, arr_rd_en & arr_wr_en}, 64'd0);
      if (arr_rd_en) begin
        check("rd_addr", arr_addr, exp_ptr);
        sb.push_back('{addr: arr_addr, data: mem[arr_addr]});
        rd_cnt++;
      end
      if (arr_wr_en) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          check("wr_addr", arr_addr, e.addr);
          check("wr_data", arr_wr_data, e.data);
        end
        exp_ptr = (exp_ptr + 1) % ROWS;
      end
      if (cycle_done) done_seen++;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, refresh_busy, 0);
    check({tag, "_done"}, cycle_done, 0);
    check({tag, "_rd"},   arr_rd_en, 0);
    check({tag, "_wr"},   arr_wr_en, 0);
    check({tag, "_addr"}, arr_addr, 0);
    check({tag, "_wdat"}, arr_wr_data, 0);
  endtask

  task automatic run_burst(input int defer, input int exp_row, input int gap);
    int cyc, first_rd, first_addr, done_cyc, rd0, d0, busy_bad, stray, exp_first;
    bit finished, exp_busy;
    first_rd = -1; first_addr = -1; done_cyc = -1; busy_bad = 0; finished = 0;
    rd0 = rd_cnt; d0 = done_seen;
    @(posedge clk); #1;
    refresh_req = 1'b1;
    user_active = (defer > 0);
    cyc = 0;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      if (arr_rd_en && first_rd < 0) begin
        first_rd   = cyc;
        first_addr = arr_addr;
      end
      exp_busy = (cyc >= 1) && (done_cyc < 0);
      if (refresh_busy !== exp_busy) busy_bad++;
      if (done_cyc >= 0) finished = 1;
      else if (cycle_done) done_cyc = cyc;
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
        user_active = (cyc < defer);
        if (done_cyc >= 0) refresh_req = 1'b0;
      end
    end
    refresh_req = 1'b0;
    user_active = 1'b0;
    if (!finished) check("burst_timeout", 64'd0, 64'd1);
    exp_first = ((defer > 1) ? defer : 1) + 1;
    check("first_rd_lat", first_rd, exp_first);
    check("first_row", first_addr, exp_row);
    check("done_lat", done_cyc - first_rd, RPR * (RD_LAT + 2));
    check("rows_read", rd_cnt - rd0, RPR);
    check("busy_window", busy_bad, 0);
    stray = 0;
    repeat (gap) begin
      @(negedge clk);
      if (arr_rd_en || arr_wr_en || refresh_busy) stray++;
    end
    check("no_restart", stray, 0);
    check("done_pulses", done_seen - d0, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  typedef struct {
    int defer;
    int exp_row;
    int gap;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    int d0, guard;
    vecs[0] = '{0, 0, 10};
    vecs[1] = '{5, 8, 10};
    vecs[2] = '{1, 16, 10};
    vecs[3] = '{0, 24, 10};
    vecs[4] = '{2, 32, 10};
    vecs[5] = '{0, 40, 10};
    vecs[6] = '{3, 48, 10};
    vecs[7] = '{0, 56, 10};
    vecs[8] = '{0, 0, 10};

    for (int i = 0; i < ROWS; i++) mem[i] = $urandom();
    for (int k = 0; k < RD_LAT; k++) begin
      hv[k] = 1'b0;
      ha[k] = '0;
    end

    rst = 1'b1; refresh_req = 1'b0; user_active = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", refresh_busy, 0);

    // reset during the latency wait of row 3 of the first burst
    d0 = done_seen;
    @(posedge clk); #1;
    refresh_req = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(arr_rd_en && arr_addr == 3) && guard < 200);
    check("row3_reached", guard < 200, 1);
    @(negedge clk);
    check("wait_busy", refresh_busy, 1);
    check("wait_no_strobe", arr_rd_en | arr_wr_en, 0);
    rst = 1'b1;
    refresh_req = 1'b0;
    #1;
    check_outputs_zero("midrst");
    sb.delete();
    exp_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_seen - d0, 0);

    // request table: restart at row 0, then walk and wrap the row pointer
    for (int i = 0; i <= 8; i++)
      run_burst(vecs[i].defer, vecs[i].exp_row, vecs[i].gap);

    // held-level counter with wide spacing: one burst per request
    for (int i = 0; i < 3; i++)
      run_burst(0, 8 + 8 * i, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
